// File: rtl/pipe_mips32_pkg.sv
// Shared definitions for the 5-stage MIPS32 subset pipeline: field positions,
// opcodes, instruction classes and pipeline-register layouts.
package pipe_mips32_pkg;

  // Instruction field positions
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  // Register-register opcodes (result to rd)
  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  // Register-memory / immediate / control opcodes (result to rt)
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  // NOP covers bubbles and undefined opcodes
  typedef enum logic [2:0] {
    NOP, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
  } instr_type_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    instr_type_t itype;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        wen;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    instr_type_t itype;
    logic [4:0]  dst;
    logic        wen;
    logic [31:0] alu;
    logic [31:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    instr_type_t itype;
    logic [4:0]  dst;
    logic        wen;
    logic [31:0] result;
  } mem_wb_t;

  function automatic instr_type_t decode_type(input logic [5:0] op);
    instr_type_t t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
      OP_LW:                                         t = LOAD;
      OP_SW:                                         t = STORE;
      OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
      OP_HLT:                                        t = HALT;
      default:                                       t = NOP;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// Combinational ALU: the opcode selects the operation; immediate and memory
// forms reuse the same datapath as their register counterparts.
module mips32_alu
  import pipe_mips32_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);

  // Operation select; undefined opcodes produce zero
  always_comb begin
    o_result = '0;
    case (i_opcode)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: o_result = i_a + i_b;
      OP_SUB, OP_SUBI:               o_result = i_a - i_b;
      OP_AND:                        o_result = i_a & i_b;
      OP_OR:                         o_result = i_a | i_b;
      OP_SLT, OP_SLTI:               o_result = {31'd0, $signed(i_a) < $signed(i_b)};
      OP_MUL:                        o_result = i_a * i_b;
      default:                       o_result = '0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// 5-stage in-order MIPS32 subset pipeline with unified word-addressed memory,
// full EX forwarding, one-cycle load-use stall, branches resolved in EX.
module pipe_mips32
  import pipe_mips32_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  if_id_t  r_if_id;
  id_ex_t  r_id_ex;
  ex_mem_t r_ex_mem;
  mem_wb_t r_mem_wb;
  logic    r_fetch_stop;

  // ID stage signals
  logic [5:0]  w_id_op;
  logic [4:0]  w_id_rs, w_id_rt, w_id_rd, w_id_dst;
  logic [31:0] w_id_imm, w_rs_val, w_rt_val;
  instr_type_t w_id_type;
  logic        w_id_wen, w_reads_rs, w_reads_rt, w_stall, w_id_hlt, w_wb_we;
  id_ex_t      w_id_next;

  // EX / MEM stage signals
  logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu_out, w_target, w_mem_result;
  logic        w_taken;
  logic [AW-1:0] w_mem_addr;

  assign w_wb_we = r_mem_wb.valid && r_mem_wb.wen && !HALTED;

  // Decode, register read with WB write-through, load-use detection
  always_comb begin
    w_id_op    = r_if_id.ir[OPC_HI:OPC_LO];
    w_id_rs    = r_if_id.ir[RS_HI:RS_LO];
    w_id_rt    = r_if_id.ir[RT_HI:RT_LO];
    w_id_rd    = r_if_id.ir[RD_HI:RD_LO];
    w_id_imm   = {{16{r_if_id.ir[IMM_HI]}}, r_if_id.ir[IMM_HI:IMM_LO]};
    w_id_type  = r_if_id.valid ? decode_type(w_id_op) : NOP;
    w_id_dst   = (w_id_type == RR_ALU) ? w_id_rd : w_id_rt;
    w_id_wen   = (w_id_type inside {RR_ALU, RM_ALU, LOAD}) && (w_id_dst != 5'd0);
    w_reads_rs = w_id_type inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
    w_reads_rt = w_id_type inside {RR_ALU, STORE};
    w_id_hlt   = (w_id_type == HALT);

    if (w_id_rs == 5'd0)                              w_rs_val = '0;
    else if (w_wb_we && r_mem_wb.dst == w_id_rs)      w_rs_val = r_mem_wb.result;
    else                                              w_rs_val = Reg[w_id_rs];
    if (w_id_rt == 5'd0)                              w_rt_val = '0;
    else if (w_wb_we && r_mem_wb.dst == w_id_rt)      w_rt_val = r_mem_wb.result;
    else                                              w_rt_val = Reg[w_id_rt];

    w_stall = r_id_ex.valid && (r_id_ex.itype == LOAD) && r_id_ex.wen &&
              ((w_reads_rs && w_id_rs == r_id_ex.dst) ||
               (w_reads_rt && w_id_rt == r_id_ex.dst));

    w_id_next = '{valid: r_if_id.valid, itype: w_id_type, op: w_id_op,
                  rs: w_id_rs, rt: w_id_rt, dst: w_id_dst, wen: w_id_wen,
                  a: w_rs_val, b: w_rt_val, imm: w_id_imm, npc: r_if_id.npc};
  end

  // EX operand forwarding (EX/MEM first, then MEM/WB) and branch resolution;
  // a load in EX/MEM is never a forwarding source because the stall covers it
  always_comb begin
    w_fwd_a = r_id_ex.a;
    if (r_ex_mem.valid && r_ex_mem.wen && r_ex_mem.itype != LOAD && r_ex_mem.dst == r_id_ex.rs)
      w_fwd_a = r_ex_mem.alu;
    else if (r_mem_wb.valid && r_mem_wb.wen && r_mem_wb.dst == r_id_ex.rs)
      w_fwd_a = r_mem_wb.result;

    w_fwd_b = r_id_ex.b;
    if (r_ex_mem.valid && r_ex_mem.wen && r_ex_mem.itype != LOAD && r_ex_mem.dst == r_id_ex.rt)
      w_fwd_b = r_ex_mem.alu;
    else if (r_mem_wb.valid && r_mem_wb.wen && r_mem_wb.dst == r_id_ex.rt)
      w_fwd_b = r_mem_wb.result;

    w_alu_b  = (r_id_ex.itype == RR_ALU) ? w_fwd_b : r_id_ex.imm;
    // BEQZ takes on zero, BNEQZ on non-zero
    w_taken  = r_id_ex.valid && (r_id_ex.itype == BRANCH) &&
               ((r_id_ex.op == OP_BEQZ) == (w_fwd_a == '0));
    w_target = r_id_ex.npc + r_id_ex.imm;
  end

  mips32_alu u_alu (
    .i_opcode (r_id_ex.op),
    .i_a      (w_fwd_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_out)
  );

  assign w_mem_addr   = r_ex_mem.alu[AW-1:0];
  assign w_mem_result = (r_ex_mem.itype == LOAD) ? Mem[w_mem_addr] : r_ex_mem.alu;

  // Pipeline registers, PC, halt and branch flag; everything freezes once halted
  always_ff @(posedge clk) begin
    if (rst) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      r_fetch_stop <= 1'b0;
      r_if_id      <= '0;
      r_id_ex      <= '0;
      r_ex_mem     <= '0;
      r_mem_wb     <= '0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= w_taken;
      // A taken branch outranks a HLT sitting in ID, since that HLT is flushed
      if (w_taken) begin
        PC           <= w_target;
        r_if_id      <= '0;
        r_fetch_stop <= 1'b0;
      end else if (w_stall) begin
        r_if_id <= r_if_id;
      end else if (w_id_hlt || r_fetch_stop) begin
        r_if_id      <= '0;
        r_fetch_stop <= 1'b1;
      end else begin
        r_if_id <= '{valid: 1'b1, ir: Mem[PC[AW-1:0]], npc: PC + 32'd1};
        PC      <= PC + 32'd1;
      end

      r_id_ex  <= (w_taken || w_stall) ? id_ex_t'('0) : w_id_next;
      r_ex_mem <= '{valid: r_id_ex.valid, itype: r_id_ex.itype, dst: r_id_ex.dst,
                    wen: r_id_ex.wen, alu: w_alu_out, sdata: w_fwd_b};
      r_mem_wb <= '{valid: r_ex_mem.valid, itype: r_ex_mem.itype, dst: r_ex_mem.dst,
                    wen: r_ex_mem.wen, result: w_mem_result};
      if (r_mem_wb.valid && r_mem_wb.itype == HALT)
        HALTED <= 1'b1;
    end
  end

  // Store in MEM stage; memory contents are not reset
  always_ff @(posedge clk) begin
    if (!rst && !HALTED && r_ex_mem.valid && r_ex_mem.itype == STORE)
      Mem[w_mem_addr] <= r_ex_mem.sdata;
  end

  // Register write-back; R0 never gets a write enable
  always_ff @(posedge clk) begin
    if (!rst && w_wb_we)
      Reg[r_mem_wb.dst] <= r_mem_wb.result;
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed-program bench for pipe_mips32 with hand-computed expected results.
module tb_pipe_mips32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] prog [0:15];
  int   prog_len;
  int   taken;

  pipe_mips32 #(.MEM_DEPTH(1024)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [31:0] HLT = {6'd63, 26'd0};

  // Hold reset, clear low memory, load program, preload Reg[k] = k (rst left high)
  task automatic load_prog();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int unsigned i = 0; i < 256; i++) dut.Mem[i] = '0;
    for (int unsigned k = 0; k < 32; k++) dut.Reg[k] = k;
    for (int unsigned i = 0; i < 16; i++) if (int'(i) < prog_len) dut.Mem[i] = prog[i];
  endtask

  task automatic run_until_halt(input int max_cyc, output int n_taken);
    n_taken = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (dut.TAKEN_BRANCH) n_taken++;
      if (dut.HALTED) return;
    end
    check("halt_timeout", {31'd0, dut.HALTED}, 32'd1);
  endtask

  task automatic load_factorial();
    prog[0] = ri(6'd10, 5'd2, 5'd0, 16'd7);      // ADDI R2,R0,7
    prog[1] = ri(6'd10, 5'd3, 5'd0, 16'd1);      // ADDI R3,R0,1
    prog[2] = ri(6'd10, 5'd4, 5'd0, 16'd0);      // ADDI R4,R0,0
    prog[3] = rr(6'd5, 5'd3, 5'd3, 5'd2);        // MUL R3,R3,R2
    prog[4] = ri(6'd11, 5'd2, 5'd2, 16'd1);      // SUBI R2,R2,1
    prog[5] = ri(6'd13, 5'd0, 5'd2, 16'hFFFD);   // BNEQZ R2,-3 -> 3
    prog[6] = ri(6'd10, 5'd4, 5'd4, 16'd1);      // ADDI R4,R4,1
    prog[7] = ri(6'd10, 5'd4, 5'd4, 16'd1);      // ADDI R4,R4,1
    prog[8] = HLT;
    prog_len = 9;
    load_prog();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", {31'd0, dut.HALTED}, 32'd0);
    check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // Load/add/store with dummy ORs between dependents
    prog[0] = ri(6'd10, 5'd1, 5'd0, 16'd120);    // ADDI R1,R0,120
    prog[1] = rr(6'd3, 5'd3, 5'd3, 5'd3);        // OR R3,R3,R3
    prog[2] = ri(6'd8, 5'd2, 5'd1, 16'd0);       // LW R2,0(R1)
    prog[3] = rr(6'd3, 5'd3, 5'd3, 5'd3);
    prog[4] = ri(6'd10, 5'd2, 5'd2, 16'd45);     // ADDI R2,R2,45
    prog[5] = rr(6'd3, 5'd3, 5'd3, 5'd3);
    prog[6] = ri(6'd9, 5'd2, 5'd1, 16'd1);       // SW R2,1(R1)
    prog[7] = HLT;
    prog[8] = ri(6'd10, 5'd12, 5'd0, 16'd99);    // past HLT: must not run
    prog_len = 9;
    load_prog();
    dut.Mem[120] = 32'd85;
    rst = 1'b0;
    run_until_halt(500, taken);
    check("p1_mem121", dut.Mem[121], 32'd130);
    check("p1_mem120", dut.Mem[120], 32'd85);
    check("p1_halted", {31'd0, dut.HALTED}, 32'd1);
    check("p1_r2", dut.Reg[2], 32'd130);
    check("p1_pc", dut.PC, 32'd8);
    repeat (5) @(negedge clk);
    check("p1_pc_frozen", dut.PC, 32'd8);
    check("p1_r12_untouched", dut.Reg[12], 32'd12);

    // Same program back-to-back: forwarding and load-use stall
    prog[0] = ri(6'd10, 5'd1, 5'd0, 16'd120);
    prog[1] = ri(6'd8, 5'd2, 5'd1, 16'd0);
    prog[2] = ri(6'd10, 5'd2, 5'd2, 16'd45);
    prog[3] = ri(6'd9, 5'd2, 5'd1, 16'd1);
    prog[4] = HLT;
    prog_len = 5;
    load_prog();
    dut.Mem[120] = 32'd85;
    rst = 1'b0;
    run_until_halt(500, taken);
    check("p2_mem121", dut.Mem[121], 32'd130);
    check("p2_mem120", dut.Mem[120], 32'd85);
    check("p2_pc", dut.PC, 32'd5);

    // ALU operations including signed compares
    prog[0]  = ri(6'd10, 5'd1, 5'd0, 16'd10);    // R1 = 10
    prog[1]  = ri(6'd10, 5'd2, 5'd0, 16'd20);    // R2 = 20
    prog[2]  = rr(6'd0, 5'd3, 5'd1, 5'd2);       // ADD R3 = 30
    prog[3]  = rr(6'd1, 5'd4, 5'd2, 5'd1);       // SUB R4 = 10
    prog[4]  = rr(6'd5, 5'd5, 5'd1, 5'd2);       // MUL R5 = 200
    prog[5]  = rr(6'd4, 5'd6, 5'd2, 5'd1);       // SLT R6 = (20<10) = 0
    prog[6]  = ri(6'd11, 5'd7, 5'd0, 16'd5);     // SUBI R7 = -5
    prog[7]  = rr(6'd4, 5'd8, 5'd7, 5'd1);       // SLT R8 = (-5<10) = 1
    prog[8]  = rr(6'd2, 5'd9, 5'd3, 5'd2);       // AND R9 = 30&20 = 20
    prog[9]  = rr(6'd3, 5'd10, 5'd1, 5'd2);      // OR R10 = 10|20 = 30
    prog[10] = ri(6'd12, 5'd11, 5'd7, 16'hFFFC); // SLTI R11 = (-5<-4) = 1
    prog[11] = HLT;
    prog_len = 12;
    load_prog();
    rst = 1'b0;
    run_until_halt(500, taken);
    check("alu_add", dut.Reg[3], 32'd30);
    check("alu_sub", dut.Reg[4], 32'd10);
    check("alu_mul", dut.Reg[5], 32'd200);
    check("alu_slt0", dut.Reg[6], 32'd0);
    check("alu_subi_neg", dut.Reg[7], 32'hFFFF_FFFB);
    check("alu_slt_signed", dut.Reg[8], 32'd1);
    check("alu_and", dut.Reg[9], 32'd20);
    check("alu_or", dut.Reg[10], 32'd30);
    check("alu_slti_neg", dut.Reg[11], 32'd1);

    // Factorial of 7 with a BNEQZ loop
    load_factorial();
    rst = 1'b0;
    run_until_halt(1000, taken);
    check("fact_r3", dut.Reg[3], 32'd5040);
    check("fact_r2", dut.Reg[2], 32'd0);
    check("fact_taken_count", taken, 32'd6);
    check("fact_flushed_r4", dut.Reg[4], 32'd2);

    // Reset in the middle of the loop, then rerun
    load_factorial();
    rst = 1'b0;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_pc", dut.PC, 32'd0);
    check("midrst_halted", {31'd0, dut.HALTED}, 32'd0);
    check("midrst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_until_halt(1000, taken);
    check("rerun_r3", dut.Reg[3], 32'd5040);
    check("rerun_taken_count", taken, 32'd6);
    check("rerun_r4", dut.Reg[4], 32'd2);

    // R0 writes ignored; undefined opcode is a NOP
    prog[0] = ri(6'd10, 5'd0, 5'd0, 16'd5);      // ADDI R0,R0,5
    prog[1] = rr(6'd0, 5'd1, 5'd0, 5'd0);        // ADD R1,R0,R0
    prog[2] = {6'h3E, 5'd2, 5'd3, 5'd4, 11'd0};  // undefined
    prog[3] = ri(6'd10, 5'd5, 5'd0, 16'd7);      // ADDI R5,R0,7
    prog[4] = HLT;
    prog_len = 5;
    load_prog();
    rst = 1'b0;
    run_until_halt(500, taken);
    check("r0_add_r1", dut.Reg[1], 32'd0);
    check("r0_reg0", dut.Reg[0], 32'd0);
    check("undef_r3", dut.Reg[3], 32'd3);
    check("undef_r4", dut.Reg[4], 32'd4);
    check("undef_next_r5", dut.Reg[5], 32'd7);
    check("undef_mem", dut.Mem[2], {6'h3E, 5'd2, 5'd3, 5'd4, 11'd0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
